// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - latency-accurate data-memory responder with valid/ready request and response channels
// One request at a time; the RAM is read or written on the edge that raises rsp_valid.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_commit;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;

  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_idle;
  logic        w_c_write;
  logic [31:0] w_c_addr;
  logic [31:0] w_c_wdata;
  logic [2:0]  w_c_funct3;
  logic [AW-1:0] w_widx;
  logic        w_oor;
  logic [1:0]  w_off;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;
  logic [3:0]  w_be;
  logic [31:0] w_sdata;
  logic        w_bad;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_we;

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = w_idle & ~rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // With LATENCY=1 the commit happens on the accept edge, so operands come straight from the request.
  assign w_c_write  = w_idle ? req_write  : r_write;
  assign w_c_addr   = w_idle ? req_addr   : r_addr;
  assign w_c_wdata  = w_idle ? req_wdata  : r_wdata;
  assign w_c_funct3 = w_idle ? req_funct3 : r_funct3;

  assign w_widx = w_c_addr[AW+1:2];
  assign w_oor  = |w_c_addr[31:AW+2];
  assign w_off  = w_c_addr[1:0];
  assign w_word = r_mem[w_widx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_c_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ldata = '0;
    w_be    = '0;
    w_sdata = '0;
    w_bad   = 1'b0;
    if (w_c_write) begin
      case (w_c_funct3)
        3'b000: begin
          w_be    = 4'b0001 << w_off;
          w_sdata = {4{w_c_wdata[7:0]}};
        end
        3'b001: begin
          w_bad   = w_off[0];
          w_be    = w_off[1] ? 4'b1100 : 4'b0011;
          w_sdata = {2{w_c_wdata[15:0]}};
        end
        3'b010: begin
          w_bad   = |w_off;
          w_be    = 4'b1111;
          w_sdata = w_c_wdata;
        end
        default: w_bad = 1'b1;
      endcase
    end else begin
      case (w_c_funct3)
        3'b000: w_ldata = {{24{w_byte[7]}}, w_byte};
        3'b100: w_ldata = {24'd0, w_byte};
        3'b001: begin
          w_bad   = w_off[0];
          w_ldata = {{16{w_half[15]}}, w_half};
        end
        3'b101: begin
          w_bad   = w_off[0];
          w_ldata = {16'd0, w_half};
        end
        3'b010: begin
          w_bad   = |w_off;
          w_ldata = w_word;
        end
        default: w_bad = 1'b1;
      endcase
    end
  end

  assign w_err   = w_bad | w_oor;
  assign w_rdata = (w_c_write | w_err) ? 32'd0 : w_ldata;
  assign w_we    = w_commit & w_c_write & ~w_err & ~rst;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_next = S_RESP;
            w_commit     = 1'b1;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = S_RESP;
          w_commit     = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_idle && req_valid) begin
        r_write  <= req_write;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
      end
      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_rdata;
        r_rsp_err   <= w_err;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  // RAM contents survive reset; only the byte lanes selected by the store change.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_sdata[8*i +: 8];
      end
    end
  end

endmodule
